// File: rtl/e_mdu_pkg.sv
// Shared constants for the multiply/divide unit: md_op encodings and default
// busy lengths, also used by the decoder and the hazard unit.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  // True for the four ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage connection between the pipeline and the multiply/divide unit.
// Handshake: start is a one-cycle request pulse; it is taken only when busy
// is low and md_op is MULT/MULTU/DIV/DIVU. busy stays high for the whole
// operation and E_HI/E_LO are only valid to consume once busy is low.
interface e_mdu_if import e_mdu_pkg::*; ();
  logic        start;
  md_op_e      md_op;
  logic [31:0] E_RS_data;
  logic [31:0] E_RT_data;
  logic        busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output start, md_op, E_RS_data, E_RT_data,
    input  busy, E_HI, E_LO
  );

  modport slave (
    input  start, md_op, E_RS_data, E_RT_data,
    output busy, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers. Operands are latched on the
// start edge, a down-counter models the fixed latency, and the result is
// computed combinationally from the latched operands and captured when the
// counter reaches zero.
module e_mdu import e_mdu_pkg::*; #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    res,
  e_mdu_if.slave  mdu
);

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  md_op_e           r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;
  logic        w_div_zero;

  assign w_prod_s = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
  assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};
  assign w_prod   = (r_op == MD_MULT) ? w_prod_s : w_prod_u;

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of relying on simulator overflow rules.
  assign w_div_zero = (r_rt == 32'd0);
  assign w_a_mag    = r_rs[31] ? (~r_rs + 32'd1) : r_rs;
  assign w_b_mag    = r_rt[31] ? (~r_rt + 32'd1) : r_rt;

  // Divide datapath; divisor zero is guarded so no X is produced.
  always_comb begin
    w_q_mag = 32'd0;
    w_r_mag = 32'd0;
    w_q_u   = 32'd0;
    w_r_u   = 32'd0;
    if (!w_div_zero) begin
      w_q_mag = w_a_mag / w_b_mag;
      w_r_mag = w_a_mag % w_b_mag;
      w_q_u   = r_rs / r_rt;
      w_r_u   = r_rs % r_rt;
    end
  end

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_q_s    = (r_rs[31] ^ r_rt[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s    = r_rs[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_div_lo = (r_op == MD_DIV) ? w_q_s : w_q_u;
  assign w_div_hi = (r_op == MD_DIV) ? w_r_s : w_r_u;

  // Reset, operation sequencing and HI/LO updates.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_rs   <= 32'd0;
      r_rt   <= 32'd0;
      r_op   <= MD_NONE;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      // New starts and MT writes are ignored while an operation is in flight.
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        if (is_div(r_op)) begin
          if (!w_div_zero) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
        end else begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
      end
    end else if (mdu.start && is_arith(mdu.md_op)) begin
      r_rs   <= mdu.E_RS_data;
      r_rt   <= mdu.E_RT_data;
      r_op   <= mdu.md_op;
      r_cnt  <= is_div(mdu.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      r_busy <= 1'b1;
    end else if (mdu.md_op == MD_MTHI) begin
      r_hi <= mdu.E_RS_data;
    end else if (mdu.md_op == MD_MTLO) begin
      r_lo <= mdu.E_RS_data;
    end
  end

  assign mdu.busy = r_busy;
  assign mdu.E_HI = r_hi;
  assign mdu.E_LO = r_lo;

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, 5, busy length in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, 10, busy length in cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 res  input  1  reset; synchronous, active-low (res==0 resets on the next posedge).
REQ-005 start  input  1  one-cycle pulse; the E-stage instruction is MULT/MULTU/DIV/DIVU.
REQ-006 md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE.
REQ-007 E_RS_data  input  32  forwarded rs operand.
REQ-008 E_RT_data  input  32  forwarded rt operand.
REQ-009 busy  output  1  operation in flight; the hazard unit stalls D on (start | busy) for any MD-class instruction.
REQ-010 E_HI  output  32  current HI register, fed to the E/M pipeline register.
REQ-011 E_LO  output  32  current LO register, fed to the E/M pipeline register.

Function
REQ-012 Start acceptance: start is accepted at a posedge with res==1, busy==0 and md_op in {MULT, MULTU, DIV, DIVU}.
- rs/rt are latched into internal operand registers.
- Counter loads MULT_CYCLES or DIV_CYCLES.
- busy goes 1 after that edge.
REQ-013 start with busy==1, or with md_op not an arithmetic op, shall be ignored; no state change.
REQ-014 Counter decrements once per cycle while busy.
- On the edge where the counter goes 1->0: HI/LO are written and busy falls at that same edge.
- Result is visible on E_HI/E_LO exactly N cycles after the start edge; busy is high for exactly N cycles.
REQ-015 MULT: {HI,LO} = signed 64-bit product.
REQ-016 MULTU: {HI,LO} = unsigned 64-bit product.
REQ-017 DIV: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
REQ-018 0x80000000 DIV 0xFFFFFFFF shall give LO=0x80000000, HI=0.
REQ-019 DIVU: LO = unsigned quotient, HI = unsigned remainder.
REQ-020 Divisor==0 (DIV/DIVU): the full DIV_CYCLES busy period still occurs; HI and LO are left unchanged at completion.
REQ-021 MTHI/MTLO, with busy==0 at a posedge: write E_RS_data to HI/LO at that edge, single cycle, no busy.
REQ-022 MTHI/MTLO with busy==1 shall be ignored; the hazard unit guarantees this does not occur.
REQ-023 Operands changing on E_RS_data/E_RT_data after the start edge shall not affect the result.
REQ-024 E_HI/E_LO are direct register outputs, with no combinational path from any input.
REQ-025 Only the register written by MTHI/MTLO changes; the other holds.

Reset
REQ-026 res==0 at a posedge shall clear HI, LO, the counter, busy and the operand registers to 0, overriding any simultaneous start or MT write.
REQ-027 Reset mid-operation shall abort it: the pending result is discarded, busy is 0 after the edge, and a start on the first cycle after reset release is accepted.

Structure
REQ-028 The md_op encodings and the MULT_CYCLES/DIV_CYCLES defaults shall live in the shared CPU constants package, used by the decoder and hazard unit.
REQ-029 The block is a single module with no sub-module; the result datapath is computed combinationally from the latched operands and captured at completion.

Verification
REQ-030 MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 MTHI 0x12345678, then DIVU with rt=0 -> busy 10 cycles; HI stays 0x12345678, LO stays at its prior value.
REQ-034 MULT started, then res=0 on the 3rd busy cycle -> next edge busy=0 and HI=LO=0; MULT 4x5 on the cycle after release -> LO=20 after 5 cycles.
REQ-035 Second start and MTLO issued while busy -> both ignored; only the first result lands, at exactly N cycles.
